// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: opcodes, widths, writeback control states and
// the writes_reg decode used by writeback and forwarding.
package pipeline_pkg;

   localparam int REG_INDEX_BIT_WIDTH = 4;
   localparam int BITWIDTH            = 32;
   localparam int OPCODE_WIDTH        = 4;

   localparam logic [OPCODE_WIDTH-1:0] OP_NOP    = 4'b0000;
   localparam logic [OPCODE_WIDTH-1:0] OP_LW     = 4'b0001;
   localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 4'b0010;
   localparam logic [OPCODE_WIDTH-1:0] OP_SW     = 4'b0011;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD    = 4'b1100;

   typedef enum logic {
      WRITE_PENDING = 1'b0,
      WRITTEN       = 1'b1
   } wb_state_t;

   function automatic logic writes_reg(input logic [OPCODE_WIDTH-1:0] op);
      return !((op == OP_NOP) || (op == OP_BRANCH) || (op == OP_SW));
   endfunction

endpackage

// File: rtl/wb_data_select.sv
// Writeback value mux: load data for LW, ALU result for everything else.
// Shared with the MEM-stage forwarding path.
module wb_data_select #(
   parameter int BITWIDTH     = 32,
   parameter int OPCODE_WIDTH = 4
) (
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic [BITWIDTH-1:0]     alu_result,
   input  logic [BITWIDTH-1:0]     load_data,
   output logic [BITWIDTH-1:0]     wb_value
);
   import pipeline_pkg::*;

   assign wb_value = (opcode == OP_LW) ? load_data : alu_result;

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with writeback select, hold/bubble control and a
// single-shot register-file write. Optional retire counter: WB_RETIRE_CNT_EN.
module wb_stage #(
   parameter int REG_INDEX_BIT_WIDTH = pipeline_pkg::REG_INDEX_BIT_WIDTH,
   parameter int BITWIDTH            = pipeline_pkg::BITWIDTH,
   parameter int OPCODE_WIDTH        = pipeline_pkg::OPCODE_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           mem_valid,
   input  logic [OPCODE_WIDTH-1:0]        mem_opcode,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] mem_index,
   input  logic [BITWIDTH-1:0]            mem_alu_result,
   input  logic [BITWIDTH-1:0]            mem_load_data,
   input  logic                           stall,
   input  logic                           flush,
   output logic                           wb_valid,
   output logic [OPCODE_WIDTH-1:0]        wb_opcode,
   output logic [REG_INDEX_BIT_WIDTH-1:0] wb_index,
   output logic [BITWIDTH-1:0]            wb_data,
   output logic                           rf_we,
   output logic [REG_INDEX_BIT_WIDTH-1:0] rf_waddr,
   output logic [BITWIDTH-1:0]            rf_wdata
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0]                    retire_count
`endif
);
   import pipeline_pkg::*;

   wb_state_t             state;
   wb_state_t             state_next;
   logic [BITWIDTH-1:0]   select_data;

   wb_data_select #(
      .BITWIDTH     (BITWIDTH),
      .OPCODE_WIDTH (OPCODE_WIDTH)
   ) u_data_select (
      .opcode     (mem_opcode),
      .alu_result (mem_alu_result),
      .load_data  (mem_load_data),
      .wb_value   (select_data)
   );

   // Flush and an invalid MEM slot both produce the same all-zero bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid  <= 1'b0;
         wb_opcode <= '0;
         wb_index  <= '0;
         wb_data   <= '0;
      end else if (flush || (!stall && !mem_valid)) begin
         wb_valid  <= 1'b0;
         wb_opcode <= '0;
         wb_index  <= '0;
         wb_data   <= '0;
      end else if (!stall) begin
         wb_valid  <= 1'b1;
         wb_opcode <= mem_opcode;
         wb_index  <= mem_index;
         wb_data   <= select_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WRITE_PENDING;
      end else begin
         state <= state_next;
      end
   end

   // Once the held instruction has written, suppress rf_we until WB reloads.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = WRITE_PENDING;
      end else if (stall) begin
         if (rf_we) begin
            state_next = WRITTEN;
         end
      end else begin
         state_next = WRITE_PENDING;
      end
   end

   assign rf_we    = wb_valid & writes_reg(wb_opcode) & (state == WRITE_PENDING)
                   & (wb_index != '0);
   assign rf_waddr = wb_index;
   assign rf_wdata = wb_data;

`ifdef WB_RETIRE_CNT_EN
   // An instruction retires whenever WB is not held, even if a flush follows it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_count <= '0;
      end else if (wb_valid && !stall) begin
         retire_count <= retire_count + 32'd1;
      end
   end
`else
   // No retire counter in this build.
`endif

endmodule
